// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath slice: default widths and opcode set.
// The register file imports this for its DW/AW defaults.
package alu_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_LSL = 4'b0001,
        OP_LSR = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SLT = 4'b0110,
        OP_MOV = 4'b0111
    } alu_op_e;

endpackage

// File: rtl/reg_file_wb_wb_buffer.sv
// One-entry write-back buffer for reg_file_wb.
// Holds the most recent accepted write for one cycle; commit_en tells the
// array to absorb pend_addr/pend_data on the next rising edge.
// Optional build macro: REG0_ZERO_EN (writes to address 0 are dropped here).
module wb_buffer
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteEn,
    input  logic [AW-1:0] Waddr,
    input  logic [DW-1:0] DataIn,
    output logic          pend_valid,
    output logic [AW-1:0] pend_addr,
    output logic [DW-1:0] pend_data,
    output logic          commit_en
);

    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q,  pend_addr_d;
    logic [DW-1:0] pend_data_q,  pend_data_d;
    logic          write_accept;

    // Decide whether this cycle's write is captured into the buffer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        write_accept = WriteEn;
`ifdef REG0_ZERO_EN
        if (Waddr == '0) begin
            write_accept = 1'b0;
        end
`endif
        pend_valid_d = write_accept;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (write_accept) begin
            pend_addr_d = Waddr;
            pend_data_d = DataIn;
        end
    end

    // Buffer registers; reset discards any uncommitted write.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign pend_data  = pend_data_q;
    assign commit_en  = pend_valid_q;

endmodule

// File: rtl/reg_file_wb.sv
// Register file feeding ALU InputA/InputB, written from ALU Out through a
// one-entry write-back buffer, plus a Zero flag latched from the ALU.
// Reads bypass from the buffer so a write is visible the cycle after its edge.
// Optional build macro: REG0_ZERO_EN (register 0 hardwired to zero).
module reg_file_wb
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] RaddrA,
    input  logic [AW-1:0] RaddrB,
    output logic [DW-1:0] DataOutA,
    output logic [DW-1:0] DataOutB,
    input  logic          WriteEn,
    input  logic [AW-1:0] Waddr,
    input  logic [DW-1:0] DataIn,
    input  logic          FlagEn,
    input  logic          ZeroIn,
    output logic          FlagZero,
    output logic          WbPending
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic          pend_valid;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic          commit_en;
    logic          flag_zero_q, flag_zero_d;

    wb_buffer #(
        .DW (DW),
        .AW (AW)
    ) u_wb_buffer (
        .Clk        (Clk),
        .Reset      (Reset),
        .WriteEn    (WriteEn),
        .Waddr      (Waddr),
        .DataIn     (DataIn),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data),
        .commit_en  (commit_en)
    );

    // Next array contents: the buffered write lands in its entry.
    always_comb begin
        regs_d = regs_q;
        if (commit_en) begin
            regs_d[pend_addr] = pend_data;
        end
`ifdef REG0_ZERO_EN
        regs_d[0] = '0;
`endif
    end

    // Storage array; every entry is cleared on reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the array is explicitly reset because reads must return 0 right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports with bypass from the pending write.
    always_comb begin
        DataOutA = regs_q[RaddrA];
        DataOutB = regs_q[RaddrB];
        if (pend_valid && (pend_addr == RaddrA)) begin
            DataOutA = pend_data;
        end
        if (pend_valid && (pend_addr == RaddrB)) begin
            DataOutB = pend_data;
        end
`ifdef REG0_ZERO_EN
        if (RaddrA == '0) begin
            DataOutA = '0;
        end
        if (RaddrB == '0) begin
            DataOutB = '0;
        end
`endif
    end

    // Zero flag: load from the ALU when enabled, otherwise hold.
    always_comb begin
        flag_zero_d = FlagEn ? ZeroIn : flag_zero_q;
    end

    // Zero flag register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flag_zero_q <= 1'b0;
        end else begin
            flag_zero_q <= flag_zero_d;
        end
    end

    assign FlagZero  = flag_zero_q;
    assign WbPending = pend_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed stimulus, a behavioural
// register-file model compared every cycle, and literal spot checks.
// Honors REG0_ZERO_EN when it is defined for the whole build.
module tb_reg_file_wb;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [AW-1:0] RaddrA, RaddrB, Waddr;
    logic [DW-1:0] DataOutA, DataOutB, DataIn;
    logic          WriteEn, FlagEn, ZeroIn, FlagZero, WbPending;

    int tests_run = 0;
    int tests_failed = 0;

    reg_file_wb #(.DW(DW), .AW(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RaddrA    (RaddrA),
        .RaddrB    (RaddrB),
        .DataOutA  (DataOutA),
        .DataOutB  (DataOutB),
        .WriteEn   (WriteEn),
        .Waddr     (Waddr),
        .DataIn    (DataIn),
        .FlagEn    (FlagEn),
        .ZeroIn    (ZeroIn),
        .FlagZero  (FlagZero),
        .WbPending (WbPending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a write is architecturally visible from the cycle
    // after its edge, so the model simply stores it at that edge.
    logic [7:0] m_mem [8];
    logic       m_pend = 1'b0;
    logic       m_flag = 1'b0;
    logic       m_on = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
            m_pend = 1'b0;
            m_flag = 1'b0;
            m_on   = 1'b1;
        end else begin
            m_pend = 1'b0;
`ifdef REG0_ZERO_EN
            if (WriteEn && Waddr != 3'd0) begin
`else
            if (WriteEn) begin
`endif
                m_mem[Waddr] = DataIn;
                m_pend = 1'b1;
            end
            if (FlagEn) m_flag = ZeroIn;
        end
    end

    function automatic logic [7:0] m_read(input logic [2:0] a);
        logic [7:0] v;
        v = m_mem[a];
`ifdef REG0_ZERO_EN
        if (a == 3'd0) v = 8'h00;
`endif
        return v;
    endfunction

    // Compare process: outputs are stable mid-cycle.
    always @(negedge Clk) begin
        if (m_on) begin
            check("cmp_dout_a", DataOutA, m_read(RaddrA));
            check("cmp_dout_b", DataOutB, m_read(RaddrB));
            check("cmp_flag", {7'b0, FlagZero}, {7'b0, m_flag});
            check("cmp_wbpend", {7'b0, WbPending}, {7'b0, m_pend});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; WriteEn = 1'b0; Waddr = '0; DataIn = '0;
        FlagEn = 1'b0; ZeroIn = 1'b0; RaddrA = '0; RaddrB = '0;
        step();
        step();
        Reset = 1'b0;

        // Reset state on every address, both ports.
        for (int i = 0; i < 8; i++) begin
            RaddrA = 3'(i);
            RaddrB = 3'(7 - i);
            #1;
            check("rst_read_a", DataOutA, 8'h00);
            check("rst_read_b", DataOutB, 8'h00);
        end
        check("rst_flag", {7'b0, FlagZero}, 8'h00);
        check("rst_wbpend", {7'b0, WbPending}, 8'h00);

        // Single write to r3 with bypass then commit.
        RaddrA = 3'd3; WriteEn = 1'b1; Waddr = 3'd3; DataIn = 8'hA5;
        step();
        WriteEn = 1'b0;
        #1;
        check("wr3_pending", {7'b0, WbPending}, 8'h01);
        check("wr3_bypass", DataOutA, 8'hA5);
        step();
        check("wr3_committed_pend", {7'b0, WbPending}, 8'h00);
        check("wr3_array", DataOutA, 8'hA5);

        // Consecutive writes to r2.
        RaddrA = 3'd2; RaddrB = 3'd2;
        #1;
        check("r2_before", DataOutA, 8'h00);
        WriteEn = 1'b1; Waddr = 3'd2; DataIn = 8'h11;
        step();
        check("r2_first_a", DataOutA, 8'h11);
        check("r2_first_b", DataOutB, 8'h11);
        DataIn = 8'h22;
        step();
        WriteEn = 1'b0;
        #1;
        check("r2_second", DataOutB, 8'h22);
        step();
        step();
        check("r2_final", DataOutA, 8'h22);
        check("r2_idle_pend", {7'b0, WbPending}, 8'h00);

        // Flag latch and hold.
        FlagEn = 1'b1; ZeroIn = 1'b1;
        step();
        FlagEn = 1'b0; ZeroIn = 1'b0;
        #1;
        check("flag_set", {7'b0, FlagZero}, 8'h01);
        step();
        step();
        check("flag_hold", {7'b0, FlagZero}, 8'h01);
        FlagEn = 1'b1; WriteEn = 1'b1; Waddr = 3'd1; DataIn = 8'h3C;
        step();
        FlagEn = 1'b0; WriteEn = 1'b0;
        #1;
        check("flag_clear", {7'b0, FlagZero}, 8'h00);

        // Back-to-back writes to distinct registers, read on both ports.
        RaddrA = 3'd6; RaddrB = 3'd7;
        WriteEn = 1'b1; Waddr = 3'd6; DataIn = 8'h5A;
        step();
        Waddr = 3'd7; DataIn = 8'hC3;
        step();
        WriteEn = 1'b0;
        #1;
        check("b2b_r6", DataOutA, 8'h5A);
        check("b2b_r7", DataOutB, 8'hC3);
        step();

        // Sweep writes across all addresses, one per cycle.
        for (int i = 1; i < 8; i++) begin
            WriteEn = 1'b1; Waddr = 3'(i); DataIn = 8'(i * 16 + i);
            RaddrA = 3'(i - 1); RaddrB = 3'(i);
            step();
        end
        WriteEn = 1'b0;
        RaddrA = 3'd4; RaddrB = 3'd7;
        #1;
        check("sweep_r4", DataOutA, 8'h44);
        check("sweep_r7", DataOutB, 8'h77);
        step();

        // Write coincident with reset is discarded.
        RaddrA = 3'd5; RaddrB = 3'd3;
        WriteEn = 1'b1; Waddr = 3'd5; DataIn = 8'hFF; Reset = 1'b1;
        step();
        Reset = 1'b0; WriteEn = 1'b0;
        #1;
        check("rstwr_pend", {7'b0, WbPending}, 8'h00);
        check("rstwr_r5", DataOutA, 8'h00);
        check("rstwr_r3", DataOutB, 8'h00);
        step();
        check("rstwr_r5_later", DataOutA, 8'h00);

        // Pending write followed by reset is discarded.
        RaddrA = 3'd4;
        WriteEn = 1'b1; Waddr = 3'd4; DataIn = 8'h33;
        step();
        WriteEn = 1'b0; Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        check("rstpend_r4", DataOutA, 8'h00);
        step();

        // Register 0 behaviour.
        RaddrA = 3'd0;
        WriteEn = 1'b1; Waddr = 3'd0; DataIn = 8'h7E;
        step();
        WriteEn = 1'b0;
        #1;
`ifdef REG0_ZERO_EN
        check("r0_pend", {7'b0, WbPending}, 8'h00);
        check("r0_read", DataOutA, 8'h00);
`else
        check("r0_pend", {7'b0, WbPending}, 8'h01);
        check("r0_read", DataOutA, 8'h7E);
`endif
        step();
`ifdef REG0_ZERO_EN
        check("r0_read_later", DataOutA, 8'h00);
`else
        check("r0_read_later", DataOutA, 8'h7E);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 8-bit register file that sits directly upstream of the ALU: its two read ports drive ALU InputA/InputB.
- Its write port takes the ALU Out result; its flag register latches the ALU Zero output for later branches.
- Writes pass through a one-entry write-back buffer and commit to the array one cycle later.
- Reads bypass from that buffer, so results are visible immediately after the write edge.

Parameters:
- DW, 8, data width; matches ALU InputA/InputB/Out.
- AW, 3, register address width; array depth is 2**AW = 8.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- RaddrA  in  AW  read address, port A (feeds ALU InputA).
- RaddrB  in  AW  read address, port B (feeds ALU InputB).
- DataOutA  out  DW  combinational read data, port A.
- DataOutB  out  DW  combinational read data, port B.
- WriteEn  in  1  write request this cycle.
- Waddr  in  AW  write address.
- DataIn  in  DW  write data (ALU Out).
- FlagEn  in  1  latch ZeroIn this cycle.
- ZeroIn  in  1  ALU Zero output.
- FlagZero  out  1  registered Zero flag.
- WbPending  out  1  write-back buffer holds an uncommitted write.

Behaviour:
- Reset (sync, high):
  - All array entries become 0; PendValid, PendAddr and PendData become 0; FlagZero becomes 0.
  - Outputs are therefore DataOutA/B = 0, FlagZero = 0, WbPending = 0 from the first cycle after the reset edge.
  - Reset overrides WriteEn and FlagEn in the same cycle; a pending uncommitted write is discarded.
- Write path, 2 stages:
  - Edge N with WriteEn=1: capture {Waddr, DataIn} into the buffer and set PendValid=1.
  - Edge N+1: commit PendData to Regs[PendAddr].
  - At edge N+1, PendValid becomes WriteEn (so a new capture can happen on the same edge).
  - WbPending = PendValid.
- Back-to-back writes:
  - Commit of the old buffer and capture of the new write happen on the same edge. No stall; sustained rate is one write per cycle.
  - Same address written on consecutive cycles: the final array value is the later DataIn. Reads in between return the buffer value.
- Read path:
  - DataOutX = (PendValid && PendAddr == RaddrX) ? PendData : Regs[RaddrX].
  - Purely combinational; zero latency from address to data.
  - No same-cycle bypass from DataIn: a write presented in cycle N is readable from cycle N+1.
- Both ports may read the same address or the pending address simultaneously; each port resolves independently.
- Flag:
  - FlagEn=1: FlagZero <= ZeroIn at the next edge.
  - FlagEn=0: hold.
  - Flag behaviour is independent of WriteEn.
- Width rules: no arithmetic in this block; DataIn is stored unmodified, all DW bits.

Optional Feature:
- Macro: REG0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0.
  - A write to Waddr=0 is dropped at capture: PendValid is not set and WbPending stays 0.
  - Reads of address 0 always return 0.
- Undefined: register 0 is an ordinary storage entry.

Decomposition:
- Shared package alu_pkg holds:
  - DW and AW defaults.
  - ALU opcode constants: ADD 4'b0000, LSL 0001, LSR 0010, AND 0011, OR 0100, XOR 0101, SLT 0110, MOV 0111.
- One natural sub-module: wb_buffer (the one-entry pending-write register: PendValid/PendAddr/PendData plus the commit strobe). The array and read mux stay in the top.

Test Plan:
- Reset, then read all 8 addresses on both ports -> every read 8'h00; FlagZero=0; WbPending=0.
- Write 8'hA5 to r3 at edge N -> WbPending=1 in cycle N+1; DataOutA(r3)=8'hA5 in cycle N+1 via bypass. With no further write, WbPending=0 in N+2 and the read is still 8'hA5 from the array.
- Consecutive writes r2=8'h11 then r2=8'h22 while RaddrA=RaddrB=2 -> reads 8'h00, 8'h11, 8'h22 in successive cycles; the array holds 8'h22 after two idle cycles.
- FlagEn=1 with ZeroIn=1, then FlagEn=0 with ZeroIn=0 -> FlagZero=1 and holds 1 until the next FlagEn.
- WriteEn=1 (r5=8'hFF) together with Reset=1 -> after the edge WbPending=0, r5 reads 8'h00, and it stays 8'h00 on the following cycle.
- With REG0_ZERO_EN: write r0=8'h7E -> WbPending stays 0 and r0 reads 8'h00. Without the macro: r0 reads 8'h7E from the cycle after the write edge.
